// File: rtl/universal_shift_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
package universal_shift_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Single-step next-value function for the shift/rotate operations; non-shift codes pass q through.
module shift_step_unit
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] q,
    input  logic             serial_in_lsb,
    input  logic             serial_in_msb,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        case (op)
            OP_SHL:  next_q = {q[WIDTH-2:0], serial_in_lsb};
            OP_SHR:  next_q = {serial_in_msb, q[WIDTH-1:1]};
            OP_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            OP_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default: next_q = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: single-cycle load/hold plus multi-step shifts and rotates
// sequenced by an IDLE/RUN FSM with a busy/done handshake.
module universal_shift_register
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_lsb,
    input  logic             serial_in_msb,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_msb,
    output logic             serial_out_lsb,
    output logic             busy,
    output logic             done
);

    // Handshake: a command is taken when op_valid=1 at a rising edge while busy=0;
    // done pulses for one cycle per accepted command and never overlaps busy.

    state_e           state, state_n;
    op_e              op_q, op_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] q, q_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] step_q;
    logic [CNT_W-1:0] count_sat;

    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .op            (op_q),
        .q             (q),
        .serial_in_lsb (serial_in_lsb),
        .serial_in_msb (serial_in_msb),
        .next_q        (step_q)
    );

    assign count_sat = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

    always_comb begin
        state_n = state;
        op_n    = op_q;
        cnt_n   = cnt;
        q_n     = q;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_e'(op))
                        OP_LOAD: begin
                            q_n    = parallel_in;
                            done_n = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
                            if (count == '0) begin
                                done_n = 1'b1;
                            end else begin
                                op_n    = op_e'(op);
                                cnt_n   = count_sat;
                                state_n = ST_RUN;
                            end
                        end
                        default: done_n = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                q_n   = step_q;
                cnt_n = cnt - CNT_W'(1);
                // Last step: hand back to IDLE with done in the same edge busy drops.
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_HOLD;
            cnt    <= '0;
            q      <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            cnt    <= cnt_n;
            q      <= q_n;
            done_q <= done_n;
        end
    end

    assign parallel_out   = q;
    assign serial_out_msb = q[WIDTH-1];
    assign serial_out_lsb = q[0];
    assign busy           = (state == ST_RUN);
    assign done           = done_q;

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register: the successor to the team's fixed 4-bit parallel-load register. It adds configurable width and seven operations: hold, parallel load, logical shift left/right, rotate left/right and arithmetic shift right. Multi-step shifts run autonomously under a command/busy/done handshake. It serves as the common serialiser/deserialiser and bit-manipulation stage in the sequential library.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH ≥ 2.
- CNT_W, $clog2(WIDTH+1) (derived localparam), width of the step count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  command strobe; sampled on clk rising edge.
- op  in  3  operation code:
  - 0 HOLD
  - 1 LOAD
  - 2 SHL
  - 3 SHR
  - 4 ROL
  - 5 ROR
  - 6 ASR
  - 7 reserved
- count  in  CNT_W  number of single-bit steps for shift/rotate ops.
- parallel_in  in  WIDTH  data for LOAD.
- serial_in_lsb  in  1  bit entering bit 0 on SHL.
- serial_in_msb  in  1  bit entering bit WIDTH-1 on SHR.
- parallel_out  out  WIDTH  register contents.
- serial_out_msb  out  1  combinational copy of parallel_out[WIDTH-1].
- serial_out_lsb  out  1  combinational copy of parallel_out[0].
- busy  out  1  high while a multi-step operation runs.
- done  out  1  one-cycle pulse marking completion of an accepted command.

## Operation
- Reset (reset_n low, asynchronous):
  - parallel_out = 0, busy = 0, done = 0.
  - FSM returns to IDLE and the step counter clears.
- FSM states:
  - IDLE: a command is accepted when op_valid=1 at an edge.
  - RUN: one step per edge until the latched count is exhausted, then back to IDLE.
- Acceptance: op, count and parallel_in are captured only when op_valid=1 and the FSM is in IDLE. op_valid while busy=1 is ignored with no side effects.
- LOAD: parallel_out ← parallel_in at the accepting edge. FSM stays IDLE.
- HOLD, reserved code 7, or any shift/rotate op with count=0: no data change. FSM stays IDLE.
- Shift/rotate with count ≥ 1:
  - count above WIDTH saturates to WIDTH.
  - FSM enters RUN and performs exactly min(count, WIDTH) steps.
- Step definitions:
  - SHL: {q[W-2:0], serial_in_lsb}
  - SHR: {serial_in_msb, q[W-1:1]}
  - ROL: {q[W-2:0], q[W-1]}
  - ROR: {q[0], q[W-1:1]}
  - ASR: {q[W-1], q[W-1:1]}
- Serial inputs are sampled live at each step edge, not latched at acceptance, so a bit stream can be fed during RUN.

## Timing
- Edge 0 = the accepting edge.
- LOAD / HOLD / zero-count commands:
  - The result is visible after edge 0.
  - done=1 for the cycle after edge 0; busy never rises.
  - The next command can be accepted at edge 1.
- N-step shift:
  - busy=1 after edge 0.
  - Steps occur at edges 1..N.
  - After edge N: busy=0, done=1 for exactly one cycle, and parallel_out holds the final value.
  - Total latency is N+1 edges.
- A new command may be accepted at the edge that ends done (back-to-back). done then rises again per the new command's rules.
- reset_n asserted mid-RUN aborts the operation: no done pulse, contents cleared. The first command after reset_n deasserts is accepted normally.
- done and busy are never high in the same cycle.

## Structure
- The shared package universal_shift_pkg holds:
  - the op code enum (OP_HOLD..OP_ASR, OP_RSVD)
  - the FSM state enum (ST_IDLE, ST_RUN)
- Sub-module shift_step_unit: a purely combinational single-step next-value function, parametrised by WIDTH, with inputs op, q, serial_in_lsb and serial_in_msb.
- The top level owns the FSM, the CNT_W down-counter, the latched op and the output registers.

## Test plan
All scenarios use WIDTH=8.
1. Reset: hold reset_n low for 2 cycles → parallel_out=0x00, busy=0, done=0. Release, then LOAD 0xA5 → parallel_out=0xA5 after edge 0, a single done pulse, busy stays 0.
2. ROL by 3 from 0xA5:
   - Values after edges 1/2/3 are 0x4B/0x96/0x2D.
   - busy is high for 3 cycles.
   - done pulses after edge 3.
3. SHR by 4 from 0x2D with serial_in_msb=1 → 0x96, 0xCB, 0xE5, 0xF2, with serial_out_lsb tracking bit 0 at each step.
4. Arithmetic shifts, run in sequence:
   - ASR count=15 from 0x80: count saturates, exactly 8 steps, result 0xFF.
   - Then ASR count=0: no change, done after edge 0 with no busy.
5. Pulse op_valid with LOAD 0x00 during an ROR run → command ignored, and the ROR result is correct.
6. Assert reset_n at step 2 of a 6-step SHL → parallel_out=0 immediately and no done pulse. Next, issue LOAD 0x3C, expecting parallel_out=0x3C and a single done pulse.
